cronometro_bcd: RTL and testbench
=================================

Name: cronometro_bcd

Overview:
- Stopwatch stage directly downstream of the frequency divider.
- Consumes the divider's slow square wave `s_clk` as a timebase and counts elapsed time in BCD as M:SS.T (minutes, seconds, tenths).
- Controlled by single-cycle start/stop/clear pulses; feeds the display driver.
- `s_clk` is treated as data, never as a clock: edge-detected in the `clk` domain.

Parameters:
- TICKS_PER_COUNT, 2, number of `s_clk` rising edges per tenth-of-second increment (20 Hz timebase → 2). Legal range 1..255.
- WRAP, 1, 1 = roll 9:59.9 → 0:00.0 and keep running; 0 = saturate at 9:59.9 and enter PAUSE.

Ports:
- clk  in  1  system clock, 100 MHz.
- reset  in  1  asynchronous, active-low reset.
- s_clk  in  1  divided timebase from the divider; registered in the `clk` domain, so no synchronizer is needed.
- start  in  1  one-cycle pulse: begin or resume counting.
- stop  in  1  one-cycle pulse: pause counting.
- clear  in  1  one-cycle pulse: zero the count and return to IDLE.
- digit0  out  4  tenths, BCD 0..9.
- digit1  out  4  seconds units, BCD 0..9.
- digit2  out  4  seconds tens, BCD 0..5.
- digit3  out  4  minutes, BCD 0..9.
- running  out  1  high while in RUN.
- overflow  out  1  one-cycle pulse on the 9:59.9 boundary increment.

Behaviour:
- Reset (reset = 0, asynchronous):
  - state = IDLE; all digits = 0; running = 0; overflow = 0.
  - Prescaler = 0; s_clk_q = 0.
- Edge detect:
  - s_clk_q <= s_clk every cycle, in every state.
  - rise = s_clk & ~s_clk_q.
  - Sampling continues while paused, so resuming never sees a stale edge.
- FSM states: IDLE, RUN, PAUSE. Registered; running = (state == RUN), registered.
  - clear in any state → IDLE; digits and prescaler zeroed on the same edge. clear has priority over start/stop.
  - IDLE: start → RUN.
  - RUN: stop → PAUSE.
  - PAUSE: start → RUN; prescaler is kept, not zeroed.
  - start and stop together, no clear: in RUN, stop wins; in IDLE/PAUSE, start wins.
  - start in RUN and stop in IDLE/PAUSE are ignored.
- Prescaler (8 bits): counts rise events only in RUN, and only if no stop/clear that cycle.
  - rise with prescaler == TICKS_PER_COUNT-1 → prescaler = 0 and the count increments on that same clk edge.
  - Otherwise rise → prescaler + 1.
- Latency: digits change at the first clk edge where s_clk = 1 and s_clk_q = 0, i.e. one cycle after the divider toggles s_clk high.
- BCD cascade:
  - digit0 wraps 9→0 with carry into digit1.
  - digit1 wraps 9→0 with carry into digit2.
  - digit2 wraps 5→0 with carry into digit3.
  - digit3 wraps 9→0 with carry out.
  - All digits update on one edge; no illegal BCD value is ever visible.
- Boundary at 9:59.9 with an increment due:
  - WRAP = 1: digits → 0:00.0, overflow = 1 for exactly one cycle, state stays RUN.
  - WRAP = 0: digits hold 9:59.9, overflow = 1 for one cycle, state → PAUSE.
    - A later start is accepted, but the next increment repeats the saturation and pause.
- Reset asserted mid-count: immediate return to reset values, independent of clk.

Decomposition:
- Shared package cronometro_pkg holds:
  - State encoding: IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2.
  - Digit limits: MAX_TENTHS = 9, MAX_SEC_U = 9, MAX_SEC_T = 5, MAX_MIN = 9.
  - BCD width = 4.
- Sub-module digito_bcd (ports: clk, reset, clr, inc, max value → q, carry) is instantiated four times in a carry chain.
  - carry is combinational: inc & (q == max).
- Edge detect, prescaler and FSM stay in the top module.

Test Plan:
- Reset then start; drive s_clk as 3 cycles high / 3 cycles low for 4 rising edges → digits reach 0:00.2, running = 1, each digit0 change one cycle after the s_clk rise.
- Count to 0:00.5, pulse stop, apply 6 rising edges, pulse start, apply 2 edges → digits stay 0:00.5 while paused, then show 0:00.6.
- Preload via 5999 increments to 9:59.9 with WRAP = 1, one more increment → 0:00.0, overflow high exactly 1 cycle, running stays 1.
- Same sequence with WRAP = 0 → digits stay 9:59.9, overflow pulses once, running = 0 next cycle.
- Pulse clear and start on the same cycle during RUN at 1:23.4 → digits 0:00.0, state IDLE, running = 0; assert reset low mid-count → all outputs 0 asynchronously, before the next clk edge.
- Pulse start and stop together in RUN, then together in PAUSE → stays PAUSE in the first case, enters RUN in the second.

Source files
------------

// File: rtl/cronometro_bcd_pkg.sv
// Shared types and constants for the BCD stopwatch.
// Latency: none (declarations only).
// Backpressure: not applicable.
package cronometro_pkg;

    localparam int BCD_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam logic [BCD_W-1:0] MAX_TENTHS = 4'd9;
    localparam logic [BCD_W-1:0] MAX_SEC_U  = 4'd9;
    localparam logic [BCD_W-1:0] MAX_SEC_T  = 4'd5;
    localparam logic [BCD_W-1:0] MAX_MIN    = 4'd9;

endpackage

// File: rtl/cronometro_bcd_digito.sv
// One BCD digit of the stopwatch: counts 0..max_val and wraps, carry out is combinational.
// Latency: q updates on the clk edge where inc is high; carry is same-cycle.
// Backpressure: none; clr overrides inc.
module digito_bcd
    import cronometro_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    input  logic [BCD_W-1:0] max_val,
    output logic [BCD_W-1:0] q,
    output logic             carry
);

    logic at_max;

    assign at_max = (q == max_val);
    assign carry  = inc & at_max;

    // Digit register: clear wins, otherwise step and wrap at the limit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc) begin
            q <= at_max ? '0 : q + 4'd1;
        end
    end

endmodule

// File: rtl/cronometro_bcd.sv
// Stopwatch M:SS.T in BCD, timed by edges of the divided s_clk sampled as data.
// Latency: digits change on the clk edge that first sees s_clk=1 with s_clk_q=0.
// Backpressure: none; start/stop/clear are single-cycle pulses, clear has priority.
module cronometro_bcd
    import cronometro_pkg::*;
#(
    parameter int TICKS_PER_COUNT = 2,
    parameter bit WRAP            = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s_clk,
    input  logic             start,
    input  logic             stop,
    input  logic             clear,
    output logic [BCD_W-1:0] digit0,
    output logic [BCD_W-1:0] digit1,
    output logic [BCD_W-1:0] digit2,
    output logic [BCD_W-1:0] digit3,
    output logic             running,
    output logic             overflow
);

    localparam logic [7:0] PRESC_LAST = 8'(TICKS_PER_COUNT - 1);

    state_t     state;
    state_t     state_nxt;
    logic       s_clk_q;
    logic       rise;
    logic [7:0] presc;
    logic       count_en;
    logic       tick;
    logic       all_max;
    logic       boundary;
    logic       inc0;
    logic       carry0;
    logic       carry1;
    logic       carry2;
    logic       carry3;

    assign rise     = s_clk & ~s_clk_q;
    // A stop or clear in the same cycle as an edge discards that edge.
    assign count_en = (state == RUN) & rise & ~stop & ~clear;
    assign tick     = count_en & (presc == PRESC_LAST);
    assign all_max  = (digit0 == MAX_TENTHS) & (digit1 == MAX_SEC_U) &
                      (digit2 == MAX_SEC_T)  & (digit3 == MAX_MIN);
    assign boundary = tick & all_max;
    // When saturating, the chain must not roll over at 9:59.9.
    assign inc0     = WRAP ? tick : (tick & ~all_max);

    // Timebase sampling runs in every state so a resume never sees a stale edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s_clk_q <= 1'b0;
        end else begin
            s_clk_q <= s_clk;
        end
    end

    // Prescaler: divides s_clk rises down to tenths; held while paused.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc <= 8'd0;
        end else if (clear) begin
            presc <= 8'd0;
        end else if (count_en) begin
            presc <= (presc == PRESC_LAST) ? 8'd0 : presc + 8'd1;
        end
    end

    // Next-state decode: clear first, then per-state start/stop handling.
    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_nxt = RUN;
                RUN: begin
                    if (stop) begin
                        state_nxt = PAUSE;
                    end else if (boundary && !WRAP) begin
                        state_nxt = PAUSE;
                    end
                end
                PAUSE:   if (start) state_nxt = RUN;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State, running flag and overflow pulse registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            running  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state    <= state_nxt;
            running  <= (state_nxt == RUN);
            overflow <= WRAP ? carry3 : boundary;
        end
    end

    digito_bcd u_tenths (
        .clk     (clk),
        .reset   (reset),
        .clr     (clear),
        .inc     (inc0),
        .max_val (MAX_TENTHS),
        .q       (digit0),
        .carry   (carry0)
    );

    digito_bcd u_sec_u (
        .clk     (clk),
        .reset   (reset),
        .clr     (clear),
        .inc     (carry0),
        .max_val (MAX_SEC_U),
        .q       (digit1),
        .carry   (carry1)
    );

    digito_bcd u_sec_t (
        .clk     (clk),
        .reset   (reset),
        .clr     (clear),
        .inc     (carry1),
        .max_val (MAX_SEC_T),
        .q       (digit2),
        .carry   (carry2)
    );

    digito_bcd u_min (
        .clk     (clk),
        .reset   (reset),
        .clr     (clear),
        .inc     (carry2),
        .max_val (MAX_MIN),
        .q       (digit3),
        .carry   (carry3)
    );

endmodule

// File: tb/tb_cronometro_bcd.sv
// Bench for the BCD stopwatch: wrapping and saturating instances share one stimulus.
// Latency: checks sample 1 time unit after each rising clk edge.
// Backpressure: not applicable.
module tb_cronometro_bcd;

    logic       clk;
    logic       reset;
    logic       s_clk;
    logic       start;
    logic       stop;
    logic       clear;

    logic [3:0] w_d0, w_d1, w_d2, w_d3;
    logic       w_run, w_ovf;
    logic [3:0] s_d0, s_d1, s_d2, s_d3;
    logic       s_run, s_ovf;
    logic [15:0] dw, ds;

    int n_cmp;
    int n_bad;

    typedef struct {
        logic        start;
        logic        stop;
        logic        clear;
        logic        sclk;
        logic [15:0] exp_d;
        logic        exp_run;
    } vec_t;

    vec_t tbl[$];

    assign dw = {w_d3, w_d2, w_d1, w_d0};
    assign ds = {s_d3, s_d2, s_d1, s_d0};

    cronometro_bcd #(.TICKS_PER_COUNT(2), .WRAP(1'b1)) dut_w (
        .clk      (clk),
        .reset    (reset),
        .s_clk    (s_clk),
        .start    (start),
        .stop     (stop),
        .clear    (clear),
        .digit0   (w_d0),
        .digit1   (w_d1),
        .digit2   (w_d2),
        .digit3   (w_d3),
        .running  (w_run),
        .overflow (w_ovf)
    );

    cronometro_bcd #(.TICKS_PER_COUNT(2), .WRAP(1'b0)) dut_s (
        .clk      (clk),
        .reset    (reset),
        .s_clk    (s_clk),
        .start    (start),
        .stop     (stop),
        .clear    (clear),
        .digit0   (s_d0),
        .digit1   (s_d1),
        .digit2   (s_d2),
        .digit3   (s_d3),
        .running  (s_run),
        .overflow (s_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_w(input string tag, input logic [15:0] d, input logic r, input logic o);
        chk({tag, " wrap.digits"},   dw,         d);
        chk({tag, " wrap.running"},  16'(w_run), 16'(r));
        chk({tag, " wrap.overflow"}, 16'(w_ovf), 16'(o));
    endtask

    task automatic chk_s(input string tag, input logic [15:0] d, input logic r, input logic o);
        chk({tag, " sat.digits"},   ds,         d);
        chk({tag, " sat.running"},  16'(s_run), 16'(r));
        chk({tag, " sat.overflow"}, 16'(s_ovf), 16'(o));
    endtask

    task automatic push(input logic st, input logic sp, input logic cl, input logic sc,
                        input logic [15:0] d, input logic r);
        vec_t v;
        v.start = st; v.stop = sp; v.clear = cl; v.sclk = sc;
        v.exp_d = d;  v.exp_run = r;
        tbl.push_back(v);
    endtask

    // One s_clk period, 3 cycles high then 3 low; the value settles on the first high row.
    task automatic pulse(input logic [15:0] d, input logic r);
        for (int i = 0; i < 3; i++) push(1'b0, 1'b0, 1'b0, 1'b1, d, r);
        for (int i = 0; i < 3; i++) push(1'b0, 1'b0, 1'b0, 1'b0, d, r);
    endtask

    task automatic rises(input int n);
        for (int i = 0; i < n; i++) begin
            s_clk = 1'b1; step();
            s_clk = 1'b0; step();
        end
    endtask

    task automatic pulse_start();
        start = 1'b1; step();
        start = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b0;
        s_clk = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        clear = 1'b0;

        // Start, then 4 rises at 2 rises per tenth -> 0:00.2.
        push(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
        pulse(16'h0000, 1'b1);
        pulse(16'h0001, 1'b1);
        pulse(16'h0001, 1'b1);
        pulse(16'h0002, 1'b1);
        // Continue to 0:00.5.
        pulse(16'h0002, 1'b1);
        pulse(16'h0003, 1'b1);
        pulse(16'h0003, 1'b1);
        pulse(16'h0004, 1'b1);
        pulse(16'h0004, 1'b1);
        pulse(16'h0005, 1'b1);
        // Stop, 6 ignored rises, resume, 2 rises -> 0:00.6.
        push(1'b0, 1'b1, 1'b0, 1'b0, 16'h0005, 1'b0);
        for (int i = 0; i < 6; i++) pulse(16'h0005, 1'b0);
        push(1'b1, 1'b0, 1'b0, 1'b0, 16'h0005, 1'b1);
        pulse(16'h0005, 1'b1);
        pulse(16'h0006, 1'b1);
        // start+stop together: in RUN stop wins, in PAUSE start wins.
        push(1'b1, 1'b1, 1'b0, 1'b0, 16'h0006, 1'b0);
        push(1'b1, 1'b1, 1'b0, 1'b0, 16'h0006, 1'b1);
        push(1'b0, 1'b0, 1'b0, 1'b0, 16'h0006, 1'b1);

        // Reset values while reset is held.
        step();
        step();
        chk_w("reset", 16'h0000, 1'b0, 1'b0);
        chk_s("reset", 16'h0000, 1'b0, 1'b0);
        reset = 1'b1;
        step();
        chk_w("post_reset", 16'h0000, 1'b0, 1'b0);

        foreach (tbl[k]) begin
            start = tbl[k].start;
            stop  = tbl[k].stop;
            clear = tbl[k].clear;
            s_clk = tbl[k].sclk;
            step();
            chk_w($sformatf("row%0d", k), tbl[k].exp_d, tbl[k].exp_run, 1'b0);
            chk_s($sformatf("row%0d", k), tbl[k].exp_d, tbl[k].exp_run, 1'b0);
        end
        start = 1'b0;
        stop  = 1'b0;
        clear = 1'b0;
        s_clk = 1'b0;
        step();

        // 0:00.6 -> 1:23.4 is 828 tenths = 1656 rises.
        rises(1656);
        chk_w("at_1234", 16'h1234, 1'b1, 1'b0);
        chk_s("at_1234", 16'h1234, 1'b1, 1'b0);

        // clear and start together: clear wins, back to IDLE.
        clear = 1'b1; start = 1'b1; step();
        clear = 1'b0; start = 1'b0;
        chk_w("clear_start", 16'h0000, 1'b0, 1'b0);
        chk_s("clear_start", 16'h0000, 1'b0, 1'b0);
        rises(2);
        chk_w("idle_no_count", 16'h0000, 1'b0, 1'b0);

        // Preload 5999 tenths -> 9:59.9.
        pulse_start();
        rises(11998);
        chk_w("at_9599", 16'h9599, 1'b1, 1'b0);
        chk_s("at_9599", 16'h9599, 1'b1, 1'b0);
        rises(1);
        chk_w("pre_boundary", 16'h9599, 1'b1, 1'b0);
        s_clk = 1'b1; step();
        chk_w("boundary", 16'h0000, 1'b1, 1'b1);
        chk_s("boundary", 16'h9599, 1'b0, 1'b1);
        s_clk = 1'b0; step();
        chk_w("after_boundary", 16'h0000, 1'b1, 1'b0);
        chk_s("after_boundary", 16'h9599, 1'b0, 1'b0);

        // Resume the saturated counter: next increment saturates again.
        pulse_start();
        chk_s("sat_resume", 16'h9599, 1'b1, 1'b0);
        rises(1);
        s_clk = 1'b1; step();
        chk_w("second_incr", 16'h0001, 1'b1, 1'b0);
        chk_s("second_incr", 16'h9599, 1'b0, 1'b1);
        s_clk = 1'b0; step();
        chk_s("second_after", 16'h9599, 1'b0, 1'b0);

        // Asynchronous reset mid-count, checked before the next clk edge.
        reset = 1'b0;
        #2;
        chk_w("async_reset", 16'h0000, 1'b0, 1'b0);
        chk_s("async_reset", 16'h0000, 1'b0, 1'b0);
        step();
        reset = 1'b1;
        s_clk = 1'b1; step();
        chk_w("reset_release", 16'h0000, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
